// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared types for the SPI command sequencer: FSM states, target selects
// and the buffered command entry.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } seq_state_t;

  localparam logic TGT_CH1 = 1'b0;
  localparam logic TGT_CH2 = 1'b1;

  typedef struct packed {
    logic        tgt;
    logic [31:0] data;
  } cmd_entry_t;

  localparam int CMD_W = $bits(cmd_entry_t);

endpackage

// File: rtl/spi_cmd_sequencer_sync_fifo.sv
// Parameterised synchronous FIFO with first-word fall-through read data.
// Pointers carry one extra MSB so full and empty stay distinct on wrap-around.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      fill
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fill    = wr_ptr - rd_ptr;

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Buffers tagged SPI register-write commands and dispatches them in order to
// two AXI-Stream channels with an idle gap. SPI_CMD_SEQUENCER_COUNT_EN adds counters.
module spi_cmd_sequencer
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic [31:0]                 s_axis_tdata,
  input  logic                        s_axis_tuser,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [31:0]                 m_axis_tdata_1,
  output logic                        m_axis_tvalid_1,
  input  logic                        m_axis_tready_1,
  output logic [31:0]                 m_axis_tdata_2,
  output logic                        m_axis_tvalid_2,
  input  logic                        m_axis_tready_2,
  output logic [$clog2(FIFO_DEPTH):0] fill,
  output logic                        busy
`ifdef SPI_CMD_SEQUENCER_COUNT_EN
  ,
  input  logic                        cnt_clear,
  output logic [CNT_WIDTH-1:0]        cmd_count_1,
  output logic [CNT_WIDTH-1:0]        cmd_count_2
`endif
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  seq_state_t state;
  seq_state_t state_nxt;
  cmd_entry_t wr_entry;
  cmd_entry_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       send_done;
  logic       hs_1;
  logic       hs_2;
  logic [GW-1:0] gap_cnt;

  assign wr_entry      = '{tgt: s_axis_tuser, data: s_axis_tdata};
  assign s_axis_tready = !fifo_full;
  assign hs_1          = m_axis_tvalid_1 && m_axis_tready_1;
  assign hs_2          = m_axis_tvalid_2 && m_axis_tready_2;
  assign busy          = !fifo_empty || (state != IDLE);

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (aresetn),
    .wr_en   (s_axis_tvalid),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .fill    (fill)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = SEND;
      SEND:    if (hs_1 || hs_2) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (gap_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    send_done = 1'b0;
    case (state)
      IDLE:    pop = !fifo_empty;
      SEND:    send_done = hs_1 || hs_2;
      default: ;
    endcase
  end

  // The unselected channel keeps its previous tdata; only its valid stays low.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tdata_1  <= '0;
      m_axis_tdata_2  <= '0;
      m_axis_tvalid_1 <= 1'b0;
      m_axis_tvalid_2 <= 1'b0;
    end else begin
      if (pop) begin
        if (head.tgt == TGT_CH1) begin
          m_axis_tdata_1  <= head.data;
          m_axis_tvalid_1 <= 1'b1;
        end else begin
          m_axis_tdata_2  <= head.data;
          m_axis_tvalid_2 <= 1'b1;
        end
      end
      if (send_done) begin
        m_axis_tvalid_1 <= 1'b0;
        m_axis_tvalid_2 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)                          gap_cnt <= '0;
    else if (send_done)                    gap_cnt <= GAP_LOAD;
    else if (state == GAP && gap_cnt != 0) gap_cnt <= gap_cnt - 1'b1;
  end

`ifdef SPI_CMD_SEQUENCER_COUNT_EN
  // Clear has priority over a coincident handshake.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cmd_count_1 <= '0;
      cmd_count_2 <= '0;
    end else if (cnt_clear) begin
      cmd_count_1 <= '0;
      cmd_count_2 <= '0;
    end else begin
      if (hs_1) cmd_count_1 <= cmd_count_1 + 1'b1;
      if (hs_2) cmd_count_2 <= cmd_count_2 + 1'b1;
    end
  end
`endif

endmodule
